// File: rtl/seven_seg.sv
// Four-digit multiplexed seven-segment driver for a common-anode display.
// Outputs are registered from the pre-increment refresh count, so they lag cnt by one cycle.
module seven_seg #(
  parameter int unsigned CNT_WIDTH = 18
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] display_0,
  input  logic [7:0] display_1,
  input  logic [7:0] display_2,
  input  logic [7:0] display_3,
  input  logic [1:0] decplace,
  output logic [7:0] seg,
  output logic [3:0] an
);

  logic [CNT_WIDTH-1:0] cnt;
  logic [1:0]           digit;
  logic [3:0]           code;
  logic [6:0]           glyph;

  assign digit = cnt[CNT_WIDTH-1 -: 2];

  always_comb begin
    code = display_0[3:0];
    case (digit)
      2'd0:    code = display_0[3:0];
      2'd1:    code = display_1[3:0];
      2'd2:    code = display_2[3:0];
      default: code = display_3[3:0];
    endcase
  end

  // Segments a..g, active-low; lowercase glyphs for b and d
  always_comb begin
    glyph = 7'h7F;
    case (code)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      an  <= '1;
      seg <= '1;
    end else begin
      cnt <= cnt + CNT_WIDTH'(1);
      an  <= ~(4'b0001 << digit);
      seg <= {(digit != decplace), glyph};
    end
  end

endmodule

// File: tb/tb_seven_seg.sv
// Self-checking bench for seven_seg with a small refresh counter (CNT_WIDTH=4, 4 cycles per digit).
module tb_seven_seg;

  localparam int unsigned W    = 4;
  localparam int unsigned SLOT = 1 << (W - 2);

  localparam logic [7:0] HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [1:0] dp = '0;
  logic [7:0] seg;
  logic [3:0] an;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;

  seven_seg #(.CNT_WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .display_0 (d0),
    .display_1 (d1),
    .display_2 (d2),
    .display_3 (d3),
    .decplace  (dp),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {an, seg} after the edge at which the free-running count equals e
  function automatic logic [11:0] model(input int e);
    int         dig;
    logic [7:0] c;
    logic [7:0] s;
    logic [3:0] a;
    dig = (e / SLOT) % 4;
    case (dig)
      0:       c = d0;
      1:       c = d1;
      2:       c = d2;
      default: c = d3;
    endcase
    s = HEX[c[3:0]];
    if (dig == int'(dp)) s[7] = 1'b0;
    a = 4'hF;
    a[dig] = 1'b0;
    return {a, s};
  endfunction

  task automatic step();
    logic [11:0] e;
    @(posedge clk);
    e = model(edges);
    edges++;
    #1;
    check("model_seg", seg, e[7:0]);
    check("model_an", {4'h0, an}, {4'h0, e[11:8]});
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_seg", seg, 8'hFF);
    check("rst_an", {4'h0, an}, 8'h0F);
    @(negedge clk);
    rstn = 1'b1;
    edges = 0;
  endtask

  typedef struct {
    logic [7:0] code;
    logic [7:0] exp_seg;
  } vec_t;

  vec_t vecs [16];

  logic [3:0] scan_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0] scan_seg [4] = '{8'hF9, 8'hA4, 8'h30, 8'h99};

  initial begin
    int dp_on;
    logic [7:0] seg_a, seg_b;

    // Reset held with arbitrary inputs
    d0 = 8'h3C; d1 = 8'h7E; d2 = 8'h81; d3 = 8'hFF; dp = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check("hold_rst_seg", seg, 8'hFF);
    check("hold_rst_an", {4'h0, an}, 8'h0F);

    // Scan order and wrap
    d0 = 8'h01; d1 = 8'h02; d2 = 8'h03; d3 = 8'h04; dp = 2'b10;
    @(negedge clk);
    rstn = 1'b1;
    edges = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      step();
      check("scan_an", {4'h0, an}, {4'h0, scan_an[(cyc - 1) / 4]});
      check("scan_seg", seg, scan_seg[(cyc - 1) / 4]);
    end
    step();
    check("wrap_an", {4'h0, an}, 8'h0E);

    // Run into digit 2, then reset mid-slot
    repeat (8) step();
    check("mid_pre_an", {4'h0, an}, 8'h0B);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_seg", seg, 8'hFF);
    check("mid_rst_an", {4'h0, an}, 8'h0F);
    @(negedge clk);
    rstn = 1'b1;
    edges = 0;
    step();
    check("mid_restart_an", {4'h0, an}, 8'h0E);

    // Decoder sweep on digit 0 with dp elsewhere; upper nibble carries junk
    for (int i = 0; i < 16; i++) begin
      vecs[i].code = {4'(i * 7 + 3), 4'(i)};
    end
    vecs[0].exp_seg  = 8'hC0; vecs[1].exp_seg  = 8'hF9; vecs[2].exp_seg  = 8'hA4; vecs[3].exp_seg  = 8'hB0;
    vecs[4].exp_seg  = 8'h99; vecs[5].exp_seg  = 8'h92; vecs[6].exp_seg  = 8'h82; vecs[7].exp_seg  = 8'hF8;
    vecs[8].exp_seg  = 8'h80; vecs[9].exp_seg  = 8'h90; vecs[10].exp_seg = 8'h88; vecs[11].exp_seg = 8'h83;
    vecs[12].exp_seg = 8'hC6; vecs[13].exp_seg = 8'hA1; vecs[14].exp_seg = 8'h86; vecs[15].exp_seg = 8'h8E;
    dp = 2'd1;
    for (int i = 0; i < 16; i++) begin
      reset_pulse();
      d0 = vecs[i].code;
      step();
      check("sweep_seg", seg, vecs[i].exp_seg);
    end

    // Upper nibble of display_1 has no effect
    d0 = 8'h00; d1 = 8'hA5; dp = 2'd0;
    reset_pulse();
    repeat (5) step();
    seg_a = seg;
    d1 = 8'h05;
    step();
    seg_b = seg;
    check("nibble_a", seg_a, 8'h92);
    check("nibble_b", seg_b, 8'h92);

    // Decimal point: exactly one slot per scan, only on the matching digit
    d0 = 8'h08; d1 = 8'h08; d2 = 8'h08; d3 = 8'h08;
    for (int p = 0; p < 4; p++) begin
      dp = 2'(p);
      reset_pulse();
      dp_on = 0;
      for (int c = 0; c < 16; c++) begin
        step();
        if (!seg[7]) begin
          dp_on++;
          check("dp_digit", {7'h0, an[p]}, 8'h00);
        end
      end
      check("dp_count", 8'(dp_on), 8'(SLOT));
    end

    // Randomized inputs against the reference model, with occasional resets
    reset_pulse();
    for (int n = 0; n < 400; n++) begin
      d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
      dp = 2'($urandom);
      if ($urandom_range(0, 49) == 0) reset_pulse();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg.md
# seven_seg

Four-digit, time-multiplexed seven-segment display driver for the board's common-anode display. It takes four 8-bit digit codes plus a decimal-point position and continuously scans the digits, one enabled at a time. It sits at board top level next to the command parser, which feeds it a constant 4-byte version stamp.

## Interface
- CNT_WIDTH, default 18: refresh counter width. Each digit is lit for 2^(CNT_WIDTH-2) clk cycles. Minimum 3.
- clk  input  1  system clock; all state updates on rising edge.
- rstn  input  1  reset; asynchronous, active-low.
- display_0  input  8  code for digit 0 (rightmost, an[0]); only bits [3:0] are decoded, bits [7:4] are ignored.
- display_1  input  8  code for digit 1 (an[1]).
- display_2  input  8  code for digit 2 (an[2]).
- display_3  input  8  code for digit 3 (leftmost, an[3]).
- decplace  input  2  index of the digit whose decimal point is lit; exactly one dp is on per scan.
- seg  output  8  segment drive, active-low: seg[0]=a, seg[1]=b … seg[6]=g, seg[7]=dp.
- an  output  4  digit enables, active-low, one-hot-zero while running.

## Operation
- Refresh counter cnt[CNT_WIDTH-1:0] free-runs, +1 every clk, wraps from all-ones to 0 with no pause.
- Digit index d = cnt[CNT_WIDTH-1:CNT_WIDTH-2]. Scan order is 0,1,2,3,0,…
- Selected code: display_d[3:0] is decoded as a hex digit to segments a–g, active-low. Values 0–F give C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
- The values above include seg[7]=1 (dp off). Lowercase glyphs are used for b and d.
- dp: seg[7]=0 when d==decplace, otherwise 1.
- an: bit d is 0, all other bits are 1.
- Inputs are sampled every cycle with no latching. An input change is visible on the next registered update of the affected digit.

## Timing
- Reset (rstn=0, asynchronous): cnt=0, an=4'b1111 (all digits off), seg=8'hFF.
- seg and an are registered. On each rising edge they load the decode of the pre-increment cnt value, and cnt increments on the same edge.
- First edge after reset release: an=1110, seg=decode(display_0). The outputs therefore lag the counter by one cycle.
- Each digit lasts exactly 2^(CNT_WIDTH-2) cycles; a full scan takes 2^CNT_WIDTH cycles.
- Digit transition: an and seg change on the same edge. There is no blanking interval.
- An input change mid-slot updates seg on the next edge if it affects the current digit.
- Reset asserted mid-scan immediately forces an=1111 and seg=FF. After release the scan restarts at digit 0.
- No handshake; the outputs never stall.
- Implementation constraints: no latches, single clock domain.

## Test plan
- Reset: hold rstn=0 with arbitrary inputs -> an=1111, seg=FF. Release with CNT_WIDTH=4 -> next edge an=1110.
- Scan order: CNT_WIDTH=4, display_0..3 = 01,02,03,04, decplace=2'b10.
  - Cycles 1–4 -> an=1110, seg=F9.
  - Cycles 5–8 -> an=1101, seg=A4.
  - Cycles 9–12 -> an=1011, seg=30 (dp on).
  - Cycles 13–16 -> an=0111, seg=99.
  - Cycle 17 -> an=1110 again (wrap).
- Decoder sweep: display_0 stepped through 00–0F while digit 0 is active -> seg matches the 16-entry table, with bit 7 =1 when decplace≠0.
- Upper nibble ignored: display_1=8'hA5 versus 8'h05 -> identical seg=92 on digit 1.
- Decimal point: decplace = 0,1,2,3 in turn -> seg[7]=0 only while the matching an bit is 0, and exactly once per scan.
- Mid-scan reset: assert rstn=0 during digit 2 -> immediate an=1111, seg=FF. After release the first active digit is digit 0.
